// File: rtl/alu_exec_seq_pkg.sv
// Shared definitions for the XM23 ALU execution sequencer: opcodes, FSM states,
// PSW bit positions, flag-update masks and the constant table.
package alu_exec_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_CAPT,
    ST_WB
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_ADDC,
    OP_SUB,
    OP_SUBC,
    OP_DADD,
    OP_CMP,
    OP_XOR,
    OP_AND,
    OP_OR,
    OP_BIT,
    OP_BIC,
    OP_BIS,
    OP_SRA,
    OP_RRC
  } alu_op_t;

  localparam int unsigned PSW_C = 0;
  localparam int unsigned PSW_Z = 1;
  localparam int unsigned PSW_N = 2;
  localparam int unsigned PSW_S = 3;
  localparam int unsigned PSW_V = 4;

  // Flag masks over PSW[4:0] = {V, S, N, Z, C}
  localparam logic [4:0] FM_ARITH = 5'b10111;
  localparam logic [4:0] FM_LOGIC = 5'b00110;
  localparam logic [4:0] FM_CARRY = 5'b00001;
  localparam logic [4:0] FM_NONE  = 5'b00000;

  function automatic logic [15:0] const_table(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'd0;
      3'd1:    c = 16'd1;
      3'd2:    c = 16'd2;
      3'd3:    c = 16'd4;
      3'd4:    c = 16'd8;
      3'd5:    c = 16'd16;
      3'd6:    c = 16'd32;
      default: c = 16'hFFFF;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_exec_seq_decode.sv
// Combinational XM23 arithmetic/logic instruction decoder: legality, ALU opcode,
// operand fields, write-back enable and the PSW flags the instruction may change.
module xm23_alu_decode
  import alu_exec_seq_pkg::*;
(
  input  logic [15:0] instr_word,
  output logic        legal,
  output logic [3:0]  alu_op,
  output logic        wb,
  output logic        rc,
  output logic [2:0]  src,
  output logic [2:0]  dst,
  output logic        writes_dst,
  output logic [4:0]  flag_mask
);

  always_comb begin
    legal      = 1'b0;
    alu_op     = OP_ADD;
    wb         = instr_word[6];
    rc         = instr_word[7];
    src        = instr_word[5:3];
    dst        = instr_word[2:0];
    writes_dst = 1'b0;
    flag_mask  = FM_NONE;
    if (instr_word[15:12] == 4'h4) begin
      if (instr_word[11:8] <= 4'd11) begin
        legal      = 1'b1;
        alu_op     = instr_word[11:8];
        writes_dst = 1'b1;
        case (alu_op_t'(instr_word[11:8]))
          OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: flag_mask = FM_ARITH;
          OP_CMP: begin
            flag_mask  = FM_ARITH;
            writes_dst = 1'b0;
          end
          OP_DADD: flag_mask = FM_CARRY;
          OP_BIT: begin
            flag_mask  = FM_LOGIC;
            writes_dst = 1'b0;
          end
          default: flag_mask = FM_LOGIC;
        endcase
      end else if (instr_word[11:8] == 4'hD && !instr_word[7] && instr_word[5:4] == 2'b00) begin
        // Single-operand form: [5:3] selects SRA/RRC, never a constant
        legal      = 1'b1;
        rc         = 1'b0;
        writes_dst = 1'b1;
        if (instr_word[3]) begin
          alu_op    = OP_RRC;
          flag_mask = FM_CARRY;
        end else begin
          alu_op    = OP_SRA;
          flag_mask = FM_NONE;
        end
      end
    end
  end

endmodule

// File: rtl/alu_exec_seq.sv
// Sequencer wrapping the external XM23 ALU: accepts one instruction, fetches
// operands, strobes the ALU, captures its outputs, writes back and merges PSW.
module alu_exec_seq
  import alu_exec_seq_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 8,
  parameter logic [15:0] PSW_RESET = 16'h0000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        instr_valid,
  output logic                        instr_ready,
  input  logic [15:0]                 instr_word,
  output logic [$clog2(NUM_REGS)-1:0] rf_addr_s,
  output logic [$clog2(NUM_REGS)-1:0] rf_addr_d,
  input  logic [15:0]                 rf_data_s,
  input  logic [15:0]                 rf_data_d,
  output logic                        rf_we,
  output logic [15:0]                 rf_wdata,
  output logic [15:0]                 alu_op1,
  output logic [15:0]                 alu_op2,
  output logic [5:0]                  alu_instr,
  output logic                        alu_instr_opt,
  output logic                        alu_E,
  input  logic [15:0]                 alu_result,
  input  logic [15:0]                 alu_psw,
  output logic [15:0]                 psw,
  output logic                        done,
  output logic                        illegal
);

  localparam int unsigned ADDR_W = $clog2(NUM_REGS);

  state_t      state, state_nxt;
  logic [15:0] ir_q;
  logic [15:0] op1_q;
  logic [15:0] op2_q;
  logic [5:0]  instr_q;
  logic        opt_q;
  logic [15:0] res_q;
  logic [4:0]  cflags_q;
  logic [15:0] psw_q;

  logic        dec_legal;
  logic [3:0]  dec_op;
  logic        dec_wb;
  logic        dec_rc;
  logic [2:0]  dec_src;
  logic [2:0]  dec_dst;
  logic        dec_writes;
  logic [4:0]  dec_mask;

  // Upper ALU PSW bits carry no flags this block owns
  logic        unused_alu_psw_hi;
  assign unused_alu_psw_hi = ^alu_psw[15:5];

  xm23_alu_decode u_decode (
    .instr_word (ir_q),
    .legal      (dec_legal),
    .alu_op     (dec_op),
    .wb         (dec_wb),
    .rc         (dec_rc),
    .src        (dec_src),
    .dst        (dec_dst),
    .writes_dst (dec_writes),
    .flag_mask  (dec_mask)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (instr_valid) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = dec_legal ? ST_EXEC : ST_IDLE;
      ST_EXEC:  state_nxt = ST_CAPT;
      ST_CAPT:  state_nxt = ST_WB;
      ST_WB:    state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    alu_E       = 1'b0;
    rf_we       = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      ST_IDLE:  instr_ready = 1'b1;
      ST_FETCH: illegal = !dec_legal;
      ST_EXEC:  alu_E = 1'b1;
      ST_WB: begin
        rf_we = dec_writes;
        done  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      instr_q  <= '0;
      opt_q    <= 1'b0;
      res_q    <= '0;
      cflags_q <= '0;
      psw_q    <= PSW_RESET;
    end else begin
      if (state == ST_IDLE && instr_valid) begin
        ir_q <= instr_word;
      end
      if (state == ST_FETCH && dec_legal) begin
        op1_q   <= rf_data_d;
        op2_q   <= dec_rc ? const_table(dec_src) : rf_data_s;
        instr_q <= {1'b0, dec_op, dec_wb};
        opt_q   <= 1'b1;
      end
      if (state == ST_CAPT) begin
        res_q    <= alu_result;
        cflags_q <= alu_psw[4:0];
      end
      // Only flags the instruction defines are taken from the ALU; the rest hold
      if (state == ST_WB) begin
        psw_q[4:0] <= (psw_q[4:0] & ~dec_mask) | (cflags_q & dec_mask);
      end
    end
  end

  assign rf_addr_s     = ADDR_W'(dec_src);
  assign rf_addr_d     = ADDR_W'(dec_dst);
  assign alu_op1       = op1_q;
  assign alu_op2       = op2_q;
  assign alu_instr     = instr_q;
  assign alu_instr_opt = opt_q;
  assign rf_wdata      = res_q;
  assign psw           = psw_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Scoreboard bench for alu_exec_seq with a behavioural ALU, register file and
// instruction-level reference model.
module tb_alu_exec_seq;

  localparam logic [15:0] PSW_RST = 16'h0000;

  typedef struct packed {
    logic        ill;
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [15:0] psw;
    logic [31:0] c0;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr_word = 16'h0000;
  logic        instr_ready;
  logic [2:0]  rf_addr_s, rf_addr_d;
  logic [15:0] rf_data_s, rf_data_d;
  logic        rf_we;
  logic [15:0] rf_wdata, alu_op1, alu_op2;
  logic [5:0]  alu_instr;
  logic        alu_instr_opt, alu_E;
  logic [15:0] alu_result = 16'h0000;
  logic [15:0] alu_psw = 16'h0000;
  logic [15:0] psw;
  logic        done, illegal;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] cyc = 0;

  sb_t         exp_q[$];
  logic        psw_pend = 1'b0;
  logic [15:0] psw_exp = 16'h0000;
  sb_t         mon_e;

  logic [15:0] rf[8];
  logic [15:0] ref_rf[8];
  logic [15:0] ref_psw = PSW_RST;
  logic [15:0] ctab[8] = '{16'd0, 16'd1, 16'd2, 16'd4, 16'd8, 16'd16, 16'd32, 16'hFFFF};
  logic        pre_we = 1'b0;
  logic [2:0]  pre_addr = 3'd0;
  logic [15:0] pre_data = 16'h0000;

  alu_exec_seq #(.NUM_REGS(8), .PSW_RESET(PSW_RST)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_word(instr_word), .rf_addr_s(rf_addr_s), .rf_addr_d(rf_addr_d),
    .rf_data_s(rf_data_s), .rf_data_d(rf_data_d), .rf_we(rf_we), .rf_wdata(rf_wdata),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_instr(alu_instr),
    .alu_instr_opt(alu_instr_opt), .alu_E(alu_E), .alu_result(alu_result),
    .alu_psw(alu_psw), .psw(psw), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rf_data_s = rf[rf_addr_s];
  assign rf_data_d = rf[rf_addr_d];
  always @(posedge clk) begin
    if (pre_we) rf[pre_addr] <= pre_data;
    else if (rf_we) rf[rf_addr_d] <= rf_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Instruction semantics: returns {V, S, N, Z, C, result[15:0]}
  function automatic logic [20:0] alu_fn(input int op, input bit wb, input logic [15:0] d,
                                         input logic [15:0] s, input bit cin);
    int unsigned n = wb ? 8 : 16;
    logic [31:0] m = wb ? 32'hFF : 32'hFFFF;
    logic [31:0] a = {16'h0, d} & m;
    logic [31:0] b = {16'h0, s} & m;
    logic [31:0] bb, sum, r, t;
    logic [15:0] res;
    bit c = 1'b0, v = 1'b0;
    r = 0;
    case (op)
      0, 1, 2, 3, 5: begin
        bb  = (op == 2 || op == 3 || op == 5) ? (~b & m) : b;
        sum = a + bb + ((op == 1 || op == 3) ? 32'(cin) : (op == 0 ? 32'd0 : 32'd1));
        r   = sum & m;
        c   = sum[n];
        v   = (a[n-1] == bb[n-1]) && (r[n-1] != a[n-1]);
      end
      4: begin
        c = cin;
        for (int i = 0; i < int'(n / 4); i++) begin
          t = ((a >> (4 * i)) & 32'hF) + ((b >> (4 * i)) & 32'hF) + 32'(c);
          if (t > 9) begin t = t - 10; c = 1'b1; end
          else c = 1'b0;
          r = r | ((t & 32'hF) << (4 * i));
        end
      end
      6: r = a ^ b;
      7, 9: r = a & b;
      8, 11: r = a | b;
      10: r = a & ~b & m;
      12: begin r = (a >> 1) | (a & (32'd1 << (n - 1))); c = a[0]; end
      default: begin r = (a >> 1) | (32'(cin) << (n - 1)); c = a[0]; end
    endcase
    res = wb ? {d[15:8], r[7:0]} : r[15:0];
    return {v, 1'b0, r[n-1], (r == 0), c, res};
  endfunction

  function automatic logic [4:0] mask_of(input int op);
    case (op)
      0, 1, 2, 3, 5: return 5'b10111;
      6, 7, 8, 9, 10, 11: return 5'b00110;
      4, 13: return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic bit legal_word(input logic [15:0] w);
    if (w[15:12] != 4'h4) return 1'b0;
    if (w[11:8] <= 4'd11) return 1'b1;
    return (w[11:8] == 4'hD) && !w[7] && (w[5:3] <= 3'd1);
  endfunction

  // Environment ALU: flags the instruction does not define come back as junk
  always @(posedge alu_E) begin
    logic [20:0] f;
    logic [4:0]  m;
    logic [15:0] g;
    #1;
    f = alu_fn(int'(alu_instr[4:1]), alu_instr[0], alu_op1, alu_op2, psw[0]);
    m = mask_of(int'(alu_instr[4:1]));
    g = 16'($urandom);
    alu_result = f[15:0];
    alu_psw = {g[15:5], (f[20:16] & m) | (g[4:0] & ~m)};
  end

  task automatic predict(input logic [15:0] w, output sb_t e);
    int op;
    logic [15:0] d, s;
    logic [20:0] f;
    logic [4:0] m;
    e = '0;
    if (!legal_word(w)) begin
      e.ill = 1'b1;
      e.psw = ref_psw;
    end else begin
      op = (w[11:8] == 4'hD) ? (w[3] ? 13 : 12) : int'(w[11:8]);
      d = ref_rf[w[2:0]];
      s = (w[7] && op < 12) ? ctab[w[5:3]] : ref_rf[w[5:3]];
      f = alu_fn(op, w[6], d, s, ref_psw[0]);
      m = mask_of(op);
      e.psw  = {ref_psw[15:5], (ref_psw[4:0] & ~m) | (f[20:16] & m)};
      e.wr   = (op != 5) && (op != 9);
      e.addr = w[2:0];
      e.data = f[15:0];
      ref_psw = e.psw;
      if (e.wr) ref_rf[e.addr] = e.data;
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (psw_pend) begin
        chk("psw", psw, psw_exp);
        psw_pend = 1'b0;
      end
      if (alu_E) begin
        if (exp_q.size() == 0) chk("alu_E_without_instr", 32'd1, 32'd0);
        else begin
          chk("alu_E_cycle", cyc, exp_q[0].c0 + 2);
          chk("alu_instr_opt", 32'(alu_instr_opt), 32'd1);
        end
      end
      if (done || illegal) begin
        if (exp_q.size() == 0) chk("retire_without_instr", 32'd1, 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          chk("illegal_flag", 32'(illegal), 32'(mon_e.ill));
          chk("retire_cycle", cyc, mon_e.c0 + (mon_e.ill ? 32'd1 : 32'd4));
          chk("rf_we", 32'(rf_we), 32'(mon_e.wr && !mon_e.ill));
          if (mon_e.wr && !mon_e.ill) begin
            chk("rf_addr_d", 32'(rf_addr_d), 32'(mon_e.addr));
            chk("rf_wdata", 32'(rf_wdata), 32'(mon_e.data));
          end
          psw_pend = 1'b1;
          psw_exp  = mon_e.psw;
        end
      end else if (rf_we) begin
        chk("stray_rf_we", 32'd1, 32'd0);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 50) begin @(negedge clk); n++; end
    if (!instr_ready) chk("ready_timeout", 32'(instr_ready), 32'd1);
  endtask

  task automatic send(input logic [15:0] w, input sb_t e_in, output logic [31:0] c0);
    sb_t e = e_in;
    wait_ready();
    c0 = cyc;
    e.c0 = cyc;
    exp_q.push_back(e);
    instr_word  = w;
    instr_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || psw_pend || !instr_ready) && n < 100) begin @(negedge clk); n++; end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic preload(input int a, input logic [15:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = 3'(a); pre_data = v;
    @(negedge clk);
    pre_we = 1'b0;
    ref_rf[a] = v;
  endtask

  task automatic issue_dir(input logic [15:0] w, input bit ill, input bit wr,
                           input logic [2:0] addr, input logic [15:0] data, input logic [15:0] p);
    sb_t e;
    logic [31:0] c0;
    e = '0;
    e.ill = ill; e.wr = wr; e.addr = addr; e.data = data; e.psw = p;
    ref_psw = p;
    if (wr && !ill) ref_rf[addr] = data;
    send(w, e, c0);
    instr_valid = 1'b0;
    wait_idle();
  endtask

  function automatic logic [15:0] rand_word();
    int unsigned k = $urandom_range(99);
    logic [15:0] w = 16'($urandom);
    if (k < 70) w[15:8] = {4'h4, 4'($urandom_range(11))};
    else if (k < 85) begin
      w[15:8] = 8'h4D; w[7] = 1'b0; w[5:3] = 3'($urandom_range(1));
    end
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sb_t e;
    logic [15:0] w;
    logic [31:0] c0, prev;
    int n;
    for (int i = 0; i < 8; i++) begin rf[i] = 16'h0; ref_rf[i] = 16'h0; end
    repeat (3) @(negedge clk);
    chk("rst_instr_ready", 32'(instr_ready), 32'd1);
    chk("rst_psw", 32'(psw), 32'(PSW_RST));
    chk("rst_alu_E", 32'(alu_E), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_alu_instr", 32'(alu_instr), 32'd0);
    rst = 1'b0;

    preload(1, 16'd3); preload(2, 16'd5);
    issue_dir(16'h400A, 0, 1, 3'd2, 16'h0008, 16'h0000);   // ADD R1,R2
    preload(0, 16'd1);
    issue_dir(16'h4588, 0, 0, 3'd0, 16'h0000, 16'h0003);   // CMP #1,R0
    preload(0, 16'h12FF);
    issue_dir(16'h40F8, 0, 1, 3'd0, 16'h12FE, 16'h0005);   // ADD.B #-1,R0
    preload(4, 16'h0001);
    issue_dir(16'h4D0C, 0, 1, 3'd4, 16'h8000, 16'h0005);   // RRC R4
    issue_dir(16'h4C00, 1, 0, 3'd0, 16'h0000, 16'h0005);   // illegal

    // Reset while the ALU strobe is high
    predict(16'h400A, e);
    send(16'h400A, e, c0);
    instr_valid = 1'b0;
    n = 0;
    while (!alu_E && n < 10) begin @(negedge clk); n++; end
    chk("reach_exec", 32'(alu_E), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_alu_E", 32'(alu_E), 32'd0);
    chk("midrst_rf_we", 32'(rf_we), 32'd0);
    chk("midrst_ready", 32'(instr_ready), 32'd1);
    chk("midrst_psw", 32'(psw), 32'(PSW_RST));
    exp_q.delete();
    psw_pend = 1'b0;
    ref_psw = PSW_RST;
    ref_rf[2] = 16'h0008;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Back-to-back with valid held high
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      w = {4'h4, 4'($urandom_range(11)), 8'($urandom)};
      predict(w, e);
      send(w, e, c0);
      if (i > 0) chk("b2b_gap", c0 - prev, 32'd5);
      prev = c0;
    end
    instr_valid = 1'b0;
    wait_idle();

    for (int i = 0; i < 8; i++) preload(i, 16'($urandom));
    for (int i = 0; i < 200; i++) begin
      w = rand_word();
      predict(w, e);
      send(w, e, c0);
      if ($urandom_range(2) == 0) begin
        instr_valid = 1'b0;
        repeat ($urandom_range(3)) @(negedge clk);
      end
    end
    instr_valid = 1'b0;
    wait_idle();
    for (int i = 0; i < 8; i++) chk("rf_final", 32'(rf[i]), 32'(ref_rf[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
